// File: rtl/instqueue_param.sv
// instqueue_param: parametrised in-order instruction buffer between IF and the decoder (optional empty-queue bypass via INSTQUEUE_BYPASS_EN)
module instqueue_param #(
    parameter int DEPTH        = 16,
    parameter int PTR_W        = 4,
    parameter int INST_W       = 32,
    parameter int PC_W         = 32,
    parameter int STALL_MARGIN = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_instqueue_en_in,
    input  logic [INST_W-1:0] if_instqueue_inst_in,
    input  logic [PC_W-1:0]   if_instqueue_pc_in,
    output logic              instqueue_if_stall_out,
    input  logic              rs_instqueue_rdy_in,
    input  logic              rob_instqueue_rdy_in,
    input  logic              rob_instqueue_rst_in,
    input  logic              decoder_instqueue_rst_in,
    input  logic              bp_instqueue_rst_in,
    output logic              instqueue_decoder_en_out,
    output logic [INST_W-1:0] instqueue_decoder_inst_out,
    output logic [PC_W-1:0]   instqueue_decoder_pc_out,
    output logic [PTR_W:0]    instqueue_count_out,
    output logic              instqueue_overflow_out
);
    localparam logic [PTR_W:0] full_count  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] stall_count = (PTR_W+1)'(DEPTH - STALL_MARGIN);
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [PTR_W:0]    count, count_nxt;
    logic              flush, pop_rdy, empty, full, push, pop, bypass;
    logic              stall_nxt, en_nxt, overflow_nxt;
    logic [INST_W-1:0] inst_nxt;
    logic [PC_W-1:0]   pc_nxt;

    assign instqueue_count_out = count;

    // event decode and next-state; all full/empty decisions use the start-of-cycle count
    always_comb begin
        flush   = rob_instqueue_rst_in | decoder_instqueue_rst_in | bp_instqueue_rst_in;
        pop_rdy = rob_instqueue_rdy_in && rs_instqueue_rdy_in;
        empty   = count == '0;
        full    = count == full_count;
`ifdef INSTQUEUE_BYPASS_EN
        bypass  = empty && if_instqueue_en_in && pop_rdy && !flush;
`else
        bypass  = 1'b0;
`endif
        push         = if_instqueue_en_in && !full && !flush && !bypass;
        pop          = pop_rdy && !empty && !flush;
        count_nxt    = flush ? '0 : count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        stall_nxt    = count_nxt >= stall_count;
        en_nxt       = pop || bypass;
        inst_nxt     = bypass ? if_instqueue_inst_in : pop ? inst_mem[head] : instqueue_decoder_inst_out;
        pc_nxt       = bypass ? if_instqueue_pc_in : pop ? pc_mem[head] : instqueue_decoder_pc_out;
        overflow_nxt = instqueue_overflow_out || (if_instqueue_en_in && full && !flush);
    end

    // pointer, count and output registers; rdy_in low freezes everything
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head                       <= '0;
            tail                       <= '0;
            count                      <= '0;
            instqueue_if_stall_out     <= 1'b0;
            instqueue_decoder_en_out   <= 1'b0;
            instqueue_decoder_inst_out <= '0;
            instqueue_decoder_pc_out   <= '0;
            instqueue_overflow_out     <= 1'b0;
        end else if (rdy_in) begin
            head                       <= flush ? '0 : head + PTR_W'(pop);
            tail                       <= flush ? '0 : tail + PTR_W'(push);
            count                      <= count_nxt;
            instqueue_if_stall_out     <= stall_nxt;
            instqueue_decoder_en_out   <= en_nxt;
            instqueue_decoder_inst_out <= inst_nxt;
            instqueue_decoder_pc_out   <= pc_nxt;
            instqueue_overflow_out     <= overflow_nxt;
        end
    end

    // entry storage; contents after reset are don't-care so no reset here
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && push) begin
            inst_mem[tail] <= if_instqueue_inst_in;
            pc_mem[tail]   <= if_instqueue_pc_in;
        end
    end
endmodule
